// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the i2c master and the i2c_slave target.
// Contents: bus widths, ACK/NACK line levels and the target state encoding.
package i2c_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned BYTE_W = 8;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_BYTE   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_BYTE   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer plus previous-value flop for one I2C pin, with
// single-clk rise/fall strobes.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset; all flops reset to 1 (idle bus)
//   pin   - raw asynchronous input
//   lvl   - synchronized level
//   rise  - one-clk strobe on a synchronized 0->1 transition
//   fall  - one-clk strobe on a synchronized 1->0 transition
module i2c_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= pin;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign lvl  = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: oversamples scl/sda, detects START/STOP, matches SLAVE_ADDR,
// accepts 1 or 2 write bytes into rx_data or returns 1 or 2 bytes of tx_data.
// Optional: define I2C_GEN_CALL_EN to also ACK the general-call address
// (7'h00, write) and treat it as a normal write.
// Ports:
//   clk       - system clock (scl phases >= 4 clk each)
//   rst       - asynchronous active-low reset
//   scl       - I2C clock from the master
//   sda       - I2C data, open-drain (0 or z)
//   two_bytes - 1 = 2-byte transfer, sampled at the address ACK
//   tx_data   - read payload, sampled at the address ACK of a read
//   rx_data   - received write payload
//   rx_valid  - one-clk pulse when rx_data updates
//   rw        - R/W bit of the last matched address
//   busy      - high from matched address until STOP / IDLE
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    input  logic        two_bytes,
    input  logic [15:0] tx_data,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        rw,
    output logic        busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk  (clk),
        .rst_n(rst),
        .pin  (scl),
        .lvl  (scl_lvl),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk  (clk),
        .rst_n(rst),
        .pin  (sda),
        .lvl  (sda_lvl),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    // scl must be high now and in the previous sample; an scl edge in the
    // same sample disqualifies the sda edge as START/STOP.
    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl & ~scl_rise;
    assign stop_det  = sda_rise & scl_lvl & ~scl_rise;

    i2c_state_e          state_q, state_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic [BYTE_W-1:0]   b0_q, b0_d;
    logic [15:0]         tx_buf_q, tx_buf_d;
    logic                two_q, two_d;
    logic                sda_oe_q, sda_oe_d;
    logic                rw_q, rw_d;
    logic                busy_q, busy_d;
    logic [15:0]         rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;

    logic [1:0] nbytes;
    assign nbytes = two_q ? 2'd2 : 2'd1;

    // Address comparison uses the 7 bits already shifted plus the live R/W bit.
    logic addr_hit;
`ifdef I2C_GEN_CALL_EN
    assign addr_hit = (shift_q[ADDR_W-1:0] == SLAVE_ADDR) ||
                      ((shift_q[ADDR_W-1:0] == '0) && (sda_lvl == 1'b0));
`else
    assign addr_hit = (shift_q[ADDR_W-1:0] == SLAVE_ADDR);
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        b0_d       = b0_q;
        tx_buf_d   = tx_buf_q;
        two_d      = two_q;
        sda_oe_d   = sda_oe_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[BYTE_W-2:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (addr_hit) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = sda_lvl;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                // First scl fall starts the ACK, second ends it.
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d   = 1'b1;
                            two_d      = two_bytes;
                            byte_cnt_d = '0;
                            if (rw_q) begin
                                // Unused low byte is padded with 1s so the line
                                // reads 8'hFF once the payload is exhausted.
                                tx_buf_d = two_bytes ? tx_data : {tx_data[7:0], 8'hFF};
                            end
                        end else begin
                            bit_cnt_d = '0;
                            if (rw_q) begin
                                state_d  = ST_RD_BYTE;
                                sda_oe_d = ~tx_buf_q[15];
                            end else begin
                                state_d  = ST_WR_BYTE;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[BYTE_W-2:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            state_d = ST_WR_ACK;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            if (byte_cnt_q < nbytes) begin
                                sda_oe_d = 1'b1;
                                if (byte_cnt_q == 2'd0) begin
                                    b0_d = shift_q;
                                end
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end else begin
                            sda_oe_d   = 1'b0;
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            bit_cnt_d  = '0;
                            state_d    = ST_WR_BYTE;
                            if (byte_cnt_q + 2'd1 == nbytes) begin
                                rx_valid_d = 1'b1;
                                rx_data_d  = two_q ? {b0_q, shift_q} : {8'h00, shift_q};
                            end
                        end
                    end
                end
                // tx_buf_q[15] is always the bit currently on (or next onto) the line.
                ST_RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_oe_d = ~tx_buf_q[15];
                        end else if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            tx_buf_d = {tx_buf_q[14:0], 1'b1};
                            state_d  = ST_RD_ACK;
                        end else begin
                            sda_oe_d = ~tx_buf_q[14];
                            tx_buf_d = {tx_buf_q[14:0], 1'b1};
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == ACK) begin
                            state_d   = ST_RD_BYTE;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            b0_q       <= '0;
            tx_buf_q   <= '1;
            two_q      <= 1'b0;
            sda_oe_q   <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            b0_q       <= b0_d;
            tx_buf_q   <= tx_buf_d;
            two_q      <= two_d;
            sda_oe_q   <= sda_oe_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rw       = rw_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged master drives scl/sda with an
// open-drain pull-up and checks ACKs, returned data and the target's outputs.
module tb_i2c_slave;

    localparam int Q = 40;  // quarter scl period in ns (4 clk)

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        scl = 1'b1;
    logic        tb_sda_low = 1'b0;
    logic        two_bytes = 1'b0;
    logic [15:0] tx_data = '0;
    wire  [15:0] rx_data;
    wire         rx_valid;
    wire         rw;
    wire         busy;
    wire         sda;

    assign sda = tb_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .two_bytes(two_bytes),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rw       (rw),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int dut_drv  = 0;

    always @(posedge clk) begin
        if (rx_valid) pulses++;
        if (sda === 1'b0 && !tb_sda_low) dut_drv++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic i2c_start();
        tb_sda_low = 1'b0;
        #Q scl = 1'b1;
        #(2*Q) tb_sda_low = 1'b1;
        #(2*Q) scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q tb_sda_low = 1'b1;
        #Q scl = 1'b1;
        #(2*Q) tb_sda_low = 1'b0;
        #(2*Q);
    endtask

    task automatic wr_bit(input logic b);
        #Q tb_sda_low = ~b;
        #Q scl = 1'b1;
        #(2*Q) scl = 1'b0;
    endtask

    task automatic rd_bit(output logic r);
        #Q tb_sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q r = sda;
        #Q scl = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(ack);
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            d[i] = b;
        end
        wr_bit(ack);
    endtask

    logic       ack;
    logic [7:0] rd;
    int         p0;
    int         d0;

    initial begin
        // reset values
        #100 rst = 1'b1;
        #40;
        check("reset_rx_data", rx_data, 16'h0000);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_rw", rw, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_sda", sda, 1'b1);

        // 1-byte write
        two_bytes = 1'b0;
        p0 = pulses;
        i2c_start();
        wr_byte(8'hA0, ack);
        check("w1_addr_ack", ack, 1'b0);
        check("w1_busy", busy, 1'b1);
        wr_byte(8'h55, ack);
        check("w1_data_ack", ack, 1'b0);
        i2c_stop();
        check("w1_rx_data", rx_data, 16'h0055);
        check("w1_pulses", pulses - p0, 1);
        check("w1_busy_after", busy, 1'b0);
        check("w1_sda_released", sda, 1'b1);

        // 2-byte write, third byte is beyond the count and must be NACKed
        two_bytes = 1'b1;
        p0 = pulses;
        i2c_start();
        wr_byte(8'hA0, ack);
        check("w2_addr_ack", ack, 1'b0);
        wr_byte(8'hAA, ack);
        check("w2_b0_ack", ack, 1'b0);
        wr_byte(8'h55, ack);
        check("w2_b1_ack", ack, 1'b0);
        wr_byte(8'h77, ack);
        check("w2_extra_nack", ack, 1'b1);
        i2c_stop();
        check("w2_rx_data", rx_data, 16'hAA55);
        check("w2_pulses", pulses - p0, 1);

        // 2-byte read with final NACK
        two_bytes = 1'b1;
        tx_data = 16'h3CC3;
        i2c_start();
        wr_byte(8'hA1, ack);
        check("r2_addr_ack", ack, 1'b0);
        check("r2_rw", rw, 1'b1);
        rd_byte(rd, 1'b0);
        check("r2_byte0", rd, 8'h3C);
        rd_byte(rd, 1'b1);
        check("r2_byte1", rd, 8'hC3);
        check("r2_busy_wait_stop", busy, 1'b1);
        i2c_stop();
        check("r2_busy_after", busy, 1'b0);
        check("r2_rx_data_kept", rx_data, 16'hAA55);

        // 1-byte read, master ACKs past the end -> 8'hFF
        two_bytes = 1'b0;
        tx_data = 16'h1234;
        i2c_start();
        wr_byte(8'hA1, ack);
        rd_byte(rd, 1'b0);
        check("r1_byte0", rd, 8'h34);
        rd_byte(rd, 1'b1);
        check("r1_pad_ff", rd, 8'hFF);
        i2c_stop();

        // wrong address 7'h51
        d0 = dut_drv;
        p0 = pulses;
        i2c_start();
        wr_byte(8'hA2, ack);
        check("bad_addr_nack", ack, 1'b1);
        check("bad_addr_busy", busy, 1'b0);
        i2c_stop();
        check("bad_addr_no_drive", dut_drv - d0, 0);
        check("bad_addr_rx_data", rx_data, 16'hAA55);
        check("bad_addr_pulses", pulses - p0, 0);

        // reset during bit 5 of a write data byte
        two_bytes = 1'b0;
        i2c_start();
        wr_byte(8'hA0, ack);
        for (int i = 0; i < 4; i++) wr_bit(1'b1);
        #Q tb_sda_low = 1'b1;
        #Q scl = 1'b1;
        #Q rst = 1'b0;
        #1;
        check("rst_mid_rx_data", rx_data, 16'h0000);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_rx_valid", rx_valid, 1'b0);
        tb_sda_low = 1'b0;
        #20 rst = 1'b1;
        #(2*Q);

        // reset while the target is driving the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) wr_bit(i == 7 || i == 5);
        tb_sda_low = 1'b0;
        #60;
        check("ack_driven", sda, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_releases_sda", sda, 1'b1);
        #20 rst = 1'b1;
        #Q scl = 1'b1;
        #(2*Q);

        // fresh write after reset
        p0 = pulses;
        i2c_start();
        wr_byte(8'hA0, ack);
        check("post_rst_addr_ack", ack, 1'b0);
        wr_byte(8'h12, ack);
        i2c_stop();
        check("post_rst_rx_data", rx_data, 16'h0012);
        check("post_rst_pulses", pulses - p0, 1);

        // repeated START: write address, then read
        two_bytes = 1'b0;
        tx_data = 16'h7E99;
        i2c_start();
        wr_byte(8'hA0, ack);
        check("rs_wr_ack", ack, 1'b0);
        check("rs_rw_write", rw, 1'b0);
        i2c_start();
        wr_byte(8'hA1, ack);
        check("rs_rd_ack", ack, 1'b0);
        check("rs_rw_read", rw, 1'b1);
        rd_byte(rd, 1'b1);
        check("rs_rd_data", rd, 8'h99);
        i2c_stop();
        check("rs_busy_after", busy, 1'b0);

        // general call
        p0 = pulses;
        i2c_start();
        wr_byte(8'h00, ack);
`ifdef I2C_GEN_CALL_EN
        check("gc_addr_ack", ack, 1'b0);
        check("gc_rw", rw, 1'b0);
        wr_byte(8'h5A, ack);
        check("gc_data_ack", ack, 1'b0);
        i2c_stop();
        check("gc_rx_data", rx_data, 16'h005A);
        check("gc_pulses", pulses - p0, 1);
`else
        check("gc_addr_nack", ack, 1'b1);
        check("gc_busy", busy, 1'b0);
        i2c_stop();
        check("gc_pulses", pulses - p0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
